// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: shared state and line-mux encodings for the UART transmit path
package uart_tx_pkg;
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
    localparam logic [1:0] MUX_IDLE  = 2'd0;
    localparam logic [1:0] MUX_START = 2'd1;
    localparam logic [1:0] MUX_DATA  = 2'd2;
    localparam logic [1:0] MUX_PAR   = 2'd3;
endpackage

// File: rtl/uart_tx_ctrl_if.sv
// uart_tx_ctrl_if: host byte handshake, serializer control and line-mux signals
interface uart_tx_ctrl_if #(parameter int DATA_WIDTH = 8);
    logic [DATA_WIDTH-1:0] in_data;
    logic                  in_valid;
    logic                  in_ready;
    logic                  par_en;
    logic                  par_odd;
    logic [DATA_WIDTH-1:0] ser_pdata;
    logic                  ser_load;
    logic                  ser_en;
    logic                  ser_done;
    logic [1:0]            mux_sel;
    logic                  par_bit;
    logic                  busy;
    logic                  frame_done;
    modport master (
        output in_data, in_valid, par_en, par_odd, ser_done,
        input  in_ready, ser_pdata, ser_load, ser_en, mux_sel, par_bit, busy, frame_done
    );
    modport slave (
        input  in_data, in_valid, par_en, par_odd, ser_done,
        output in_ready, ser_pdata, ser_load, ser_en, mux_sel, par_bit, busy, frame_done
    );
endinterface

// File: rtl/uart_parity_calc.sv
// uart_parity_calc: even/odd parity of a data word
module uart_parity_calc #(
    parameter int DATA_WIDTH = 8
) (
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_odd,
    output logic                  o_par
);
    assign o_par = (^i_data) ^ i_odd;
endmodule

// File: rtl/uart_tx_ctrl.sv
// uart_tx_ctrl: UART transmit frame sequencer with a one-entry byte buffer
module uart_tx_ctrl
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int STOP_BITS  = 1
) (
    input logic           clk,
    input logic           rst,
    uart_tx_ctrl_if.slave bus
);
    state_t                r_state;
    state_t                w_next;
    logic [DATA_WIDTH-1:0] r_buf;
    logic                  r_full;
    logic                  r_par_en;
    logic                  r_par_bit;
    logic                  r_stop_cnt;
    logic                  w_load;
    logic                  w_en;
    logic                  w_done;
    logic                  w_last_stop;
    logic                  w_par;
    logic [1:0]            w_sel;

    uart_parity_calc #(.DATA_WIDTH(DATA_WIDTH)) u_par (
        .i_data (r_buf),
        .i_odd  (bus.par_odd),
        .o_par  (w_par)
    );

    assign w_last_stop = (STOP_BITS == 1) || r_stop_cnt;

    always_comb begin
        w_next = r_state;
        w_load = 1'b0;
        w_en   = 1'b0;
        w_done = 1'b0;
        w_sel  = MUX_IDLE;
        case (r_state)
            IDLE: begin
                w_load = r_full;
                w_next = r_full ? START : IDLE;
            end
            START: begin
                w_sel  = MUX_START;
                w_en   = 1'b1;
                w_next = DATA;
            end
            DATA: begin
                w_sel  = MUX_DATA;
                w_en   = !bus.ser_done;
                w_next = !bus.ser_done ? DATA : r_par_en ? PARITY : STOP;
            end
            PARITY: begin
                w_sel  = MUX_PAR;
                w_next = STOP;
            end
            STOP: begin
                // the next frame's load overlaps the final stop bit to avoid an idle gap
                w_done = w_last_stop;
                w_load = w_last_stop && r_full;
                w_next = !w_last_stop ? STOP : r_full ? START : IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= IDLE;
            r_buf      <= '0;
            r_full     <= 1'b0;
            r_par_en   <= 1'b0;
            r_par_bit  <= 1'b0;
            r_stop_cnt <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_stop_cnt <= (r_state == STOP) && !w_last_stop;
            if (bus.in_valid && !r_full) begin
                r_buf  <= bus.in_data;
                r_full <= 1'b1;
            end else if (w_load) begin
                r_full <= 1'b0;
            end
            if (w_load) begin
                r_par_en  <= bus.par_en;
                r_par_bit <= w_par;
            end
        end
    end

    assign bus.in_ready   = !r_full;
    assign bus.ser_pdata  = r_buf;
    assign bus.ser_load   = w_load;
    assign bus.ser_en     = w_en;
    assign bus.mux_sel    = w_sel;
    assign bus.par_bit    = r_par_bit;
    assign bus.busy       = (r_state != IDLE);
    assign bus.frame_done = w_done;
endmodule

// File: tb/tb_uart_tx_ctrl.sv
// tb_uart_tx_ctrl: two controllers (1 and 2 stop bits) with serializer and line mux vs a frame-level model
module tb_uart_tx_ctrl;
    typedef struct packed {logic b; logic [1:0] k; logic en;} fb_t;
    localparam logic [16:0] RST_OBS = 17'h00081;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  in_data  [2];
    logic        in_valid [2];
    logic        par_en   [2];
    logic        par_odd  [2];
    logic        rdy      [2];
    logic [16:0] obs      [2];
    int          n_err = 0;
    int          n_chk = 0;

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : gen_u
        uart_tx_ctrl_if #(.DATA_WIDTH(8)) ifc ();
        uart_tx_ctrl #(.DATA_WIDTH(8), .STOP_BITS(g + 1)) dut (
            .clk (clk),
            .rst (rst),
            .bus (ifc)
        );
        logic [7:0] sr;
        logic [3:0] cnt;
        logic       sout;
        logic       line;
        assign ifc.in_data  = in_data[g];
        assign ifc.in_valid = in_valid[g];
        assign ifc.par_en   = par_en[g];
        assign ifc.par_odd  = par_odd[g];
        assign ifc.ser_done = (cnt == 4'd8);
        assign rdy[g] = ifc.in_ready;
        assign line = ifc.mux_sel == 2'd0 ? 1'b1 : ifc.mux_sel == 2'd1 ? 1'b0 :
                      ifc.mux_sel == 2'd2 ? sout : ifc.par_bit;
        assign obs[g] = {ifc.ser_pdata, ifc.par_bit, ifc.in_ready, ifc.ser_load, ifc.ser_en,
                         ifc.mux_sel, ifc.busy, ifc.frame_done, line};

        always @(posedge clk or negedge rst) begin
            if (!rst) begin
                sr   <= '0;
                cnt  <= '0;
                sout <= 1'b1;
            end else if (ifc.ser_load) begin
                sr  <= ifc.ser_pdata;
                cnt <= '0;
            end else if (ifc.ser_en) begin
                sout <= sr[0];
                sr   <= sr >> 1;
                cnt  <= cnt + 4'd1;
            end
        end

        fb_t        q[$];
        logic       m_full;
        logic [7:0] m_buf;
        logic       m_par;

        always @(negedge clk) begin
            fb_t         c;
            logic        ld;
            logic        acc;
            logic [16:0] e;
            if (!rst) begin
                q.delete();
                m_full = 1'b0;
                m_buf  = '0;
                m_par  = 1'b0;
            end
            c  = q.size() > 0 ? q[0] : 4'b1000;
            ld = rst && m_full && q.size() <= 1;
            e  = {m_buf, m_par, !m_full, ld, c.en, c.k, q.size() > 0, q.size() == 1, c.b};
            chk($sformatf("u%0d_cycle", g), obs[g], e);
            if (rst) begin
                acc = in_valid[g] && !m_full;
                if (q.size() > 0) void'(q.pop_front());
                if (ld) begin
                    m_par = (^m_buf) ^ par_odd[g];
                    q.push_back({1'b0, 2'd1, 1'b1});
                    for (int i = 0; i < 8; i++) q.push_back({m_buf[i], 2'd2, i < 7});
                    if (par_en[g]) q.push_back({m_par, 2'd3, 1'b0});
                    for (int i = 0; i <= g; i++) q.push_back({1'b1, 2'd0, 1'b0});
                    m_full = 1'b0;
                end
                if (acc) begin
                    m_buf  = in_data[g];
                    m_full = 1'b1;
                end
            end
        end
    end

    task automatic send(input int k, input logic [7:0] d, input logic pe, input logic po);
        bit ok = 1'b0;
        in_data[k]  = d;
        par_en[k]   = pe;
        par_odd[k]  = po;
        in_valid[k] = 1'b1;
        for (int t = 0; t < 100 && !ok; t++) begin
            @(negedge clk);
            ok = rdy[k];
            @(posedge clk);
            #1;
        end
        in_valid[k] = 1'b0;
        if (!ok) chk($sformatf("u%0d_send_timeout", k), 32'd0, 32'd1);
    endtask

    task automatic gap(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b0;
        for (int k = 0; k < 2; k++) begin
            in_data[k]  = '0;
            in_valid[k] = 1'b0;
            par_en[k]   = 1'b0;
            par_odd[k]  = 1'b0;
        end
        gap(3);
        chk("reset_u0", obs[0], RST_OBS);
        chk("reset_u1", obs[1], RST_OBS);
        rst = 1'b1;
        gap(2);
        send(0, 8'hA5, 1'b1, 1'b0);
        gap(16);
        send(0, 8'h00, 1'b1, 1'b1);
        gap(16);
        send(0, 8'hFF, 1'b1, 1'b0);
        gap(16);
        send(0, 8'h96, 1'b0, 1'b0);
        gap(16);
        send(0, 8'h55, 1'b1, 1'b0);
        send(0, 8'h3C, 1'b1, 1'b0);
        gap(30);
        send(1, 8'h81, 1'b0, 1'b0);
        gap(16);
        send(0, 8'h07, 1'b1, 1'b1);
        gap(4);
        par_odd[0] = 1'b0;
        send(0, 8'h07, 1'b1, 1'b0);
        gap(30);
        send(0, 8'hC3, 1'b1, 1'b0);
        repeat (6) @(posedge clk);
        #3 rst = 1'b0;
        #1 chk("async_rst_u0", obs[0], RST_OBS);
        gap(2);
        rst = 1'b1;
        gap(1);
        send(0, 8'h12, 1'b1, 1'b0);
        gap(16);
        for (int n = 0; n < 40; n++) begin
            send(n % 2, 8'($urandom), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 3) == 0) par_odd[n % 2] = ~par_odd[n % 2];
            gap($urandom_range(0, 14));
        end
        gap(40);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
